// File: rtl/ysyx_040729_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040729_pkg
// Brief    : Shared encodings for the sequential RV64M divider.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_040729_pkg;

    localparam logic [2:0] FUNC3_DIV  = 3'b100;
    localparam logic [2:0] FUNC3_DIVU = 3'b101;
    localparam logic [2:0] FUNC3_REM  = 3'b110;
    localparam logic [2:0] FUNC3_REMU = 3'b111;

    localparam int DIV_CNT_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_040729_div_prep.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040729_div_prep
// Brief    : Operand narrowing, magnitudes, sign flags and special-case result.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_040729_div_prep
    import ysyx_040729_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_unsigned,
    input  logic                  i_rem_sel,
    input  logic                  i_len_dw,
    input  logic [DATA_WIDTH-1:0] i_src1,
    input  logic [DATA_WIDTH-1:0] i_src2,
    output logic [DATA_WIDTH-1:0] o_abs_a,
    output logic [DATA_WIDTH-1:0] o_abs_b,
    output logic                  o_q_neg,
    output logic                  o_r_neg,
    output logic                  o_special,
    output logic [DATA_WIDTH-1:0] o_special_result
);

    localparam int c_half = DATA_WIDTH / 2;

    logic [DATA_WIDTH-1:0] w_a_sext_lo;
    logic [DATA_WIDTH-1:0] w_b_sext_lo;
    logic [DATA_WIDTH-1:0] w_a_ext;
    logic [DATA_WIDTH-1:0] w_b_ext;
    logic [DATA_WIDTH-1:0] w_min_neg;
    logic [DATA_WIDTH-1:0] w_rem_dz;
    logic                  w_a_sign;
    logic                  w_b_sign;
    logic                  w_b_zero;
    logic                  w_ovf;

    assign w_a_sext_lo = {{c_half{i_src1[c_half-1]}}, i_src1[c_half-1:0]};
    assign w_b_sext_lo = {{c_half{i_src2[c_half-1]}}, i_src2[c_half-1:0]};

    // After extension the MSB always carries the sign of the N-bit operand.
    assign w_a_ext = !i_len_dw ? i_src1 :
                     i_unsigned ? {{c_half{1'b0}}, i_src1[c_half-1:0]} : w_a_sext_lo;
    assign w_b_ext = !i_len_dw ? i_src2 :
                     i_unsigned ? {{c_half{1'b0}}, i_src2[c_half-1:0]} : w_b_sext_lo;

    assign w_a_sign = !i_unsigned && w_a_ext[DATA_WIDTH-1];
    assign w_b_sign = !i_unsigned && w_b_ext[DATA_WIDTH-1];

    assign o_abs_a = w_a_sign ? -w_a_ext : w_a_ext;
    assign o_abs_b = w_b_sign ? -w_b_ext : w_b_ext;
    assign o_q_neg = w_a_sign ^ w_b_sign;
    assign o_r_neg = w_a_sign;

    assign w_min_neg = i_len_dw ? {{(c_half+1){1'b1}}, {(c_half-1){1'b0}}}
                                : {1'b1, {(DATA_WIDTH-1){1'b0}}};

    assign w_b_zero  = (w_b_ext == '0);
    assign w_ovf     = !i_unsigned && (w_a_ext == w_min_neg) && (w_b_ext == '1);
    assign o_special = w_b_zero || w_ovf;

    // W results are always sign-extended from bit N-1, even for REMUW.
    assign w_rem_dz = i_len_dw ? w_a_sext_lo : i_src1;

    always_comb begin
        o_special_result = '0;
        if (w_b_zero) begin
            o_special_result = i_rem_sel ? w_rem_dz : '1;
        end else if (w_ovf) begin
            o_special_result = i_rem_sel ? '0 : w_a_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_040729_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_040729_div_seq
// Brief    : Radix-2 restoring divider for RV64M DIV/REM and W variants.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_040729_div_seq
    import ysyx_040729_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    input  logic [2:0]            func3,
    input  logic                  len_dw,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int                   c_half     = DATA_WIDTH / 2;
    localparam logic [DIV_CNT_W-1:0] c_cnt_full = DIV_CNT_W'(DATA_WIDTH);
    localparam logic [DIV_CNT_W-1:0] c_cnt_half = DIV_CNT_W'(DATA_WIDTH / 2);
    localparam logic [DIV_CNT_W-1:0] c_cnt_one  = DIV_CNT_W'(1);

    div_state_t                r_state;
    logic [DIV_CNT_W-1:0]      r_cnt;
    logic [2*DATA_WIDTH-1:0]   r_rq;
    logic [DATA_WIDTH-1:0]     r_divisor;
    logic [DATA_WIDTH-1:0]     r_result;
    logic                      r_q_neg;
    logic                      r_r_neg;
    logic                      r_rem_sel;
    logic                      r_len_dw;
    logic                      r_out_valid;

    logic [DATA_WIDTH-1:0]     w_abs_a;
    logic [DATA_WIDTH-1:0]     w_abs_b;
    logic                      w_q_neg;
    logic                      w_r_neg;
    logic                      w_special;
    logic [DATA_WIDTH-1:0]     w_special_result;
    logic [DATA_WIDTH-1:0]     w_dividend;
    logic [DATA_WIDTH:0]       w_diff;
    logic                      w_ge;
    logic [2*DATA_WIDTH-1:0]   w_rq_next;
    logic [DATA_WIDTH-1:0]     w_quo;
    logic [DATA_WIDTH-1:0]     w_rem;
    logic [DATA_WIDTH-1:0]     w_sel;
    logic [DATA_WIDTH-1:0]     w_fix_result;
    logic                      w_unused_func3;

    // func3[2] only distinguishes M-extension div ops from mul ops upstream.
    assign w_unused_func3 = func3[2];

    ysyx_040729_div_prep #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prep (
        .i_unsigned       (func3[0]),
        .i_rem_sel        (func3[1]),
        .i_len_dw         (len_dw),
        .i_src1           (src1),
        .i_src2           (src2),
        .o_abs_a          (w_abs_a),
        .o_abs_b          (w_abs_b),
        .o_q_neg          (w_q_neg),
        .o_r_neg          (w_r_neg),
        .o_special        (w_special),
        .o_special_result (w_special_result)
    );

    // Left-align a W dividend so N iterations leave the quotient in the low bits.
    assign w_dividend = len_dw ? {w_abs_a[c_half-1:0], {c_half{1'b0}}} : w_abs_a;

    // Partial remainder can reach 2*divisor after the shift, hence N+1 bits.
    assign w_diff    = r_rq[2*DATA_WIDTH-1:DATA_WIDTH-1] - {1'b0, r_divisor};
    assign w_ge      = ~w_diff[DATA_WIDTH];
    assign w_rq_next = w_ge ? {w_diff[DATA_WIDTH-1:0], r_rq[DATA_WIDTH-2:0], 1'b1}
                            : {r_rq[2*DATA_WIDTH-2:0], 1'b0};

    assign w_quo = r_q_neg ? -r_rq[DATA_WIDTH-1:0] : r_rq[DATA_WIDTH-1:0];
    assign w_rem = r_r_neg ? -r_rq[2*DATA_WIDTH-1:DATA_WIDTH]
                           : r_rq[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_sel = r_rem_sel ? w_rem : w_quo;
    assign w_fix_result = r_len_dw ? {{c_half{w_sel[c_half-1]}}, w_sel[c_half-1:0]}
                                   : w_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rq        <= '0;
            r_divisor   <= '0;
            r_result    <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_rem_sel   <= 1'b0;
            r_len_dw    <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q_neg   <= w_q_neg;
                        r_r_neg   <= w_r_neg;
                        r_rem_sel <= func3[1];
                        r_len_dw  <= len_dw;
                        r_divisor <= w_abs_b;
                        r_rq      <= {{DATA_WIDTH{1'b0}}, w_dividend};
                        r_cnt     <= len_dw ? c_cnt_half : c_cnt_full;
                        if (w_special) begin
                            r_result    <= w_special_result;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_rq  <= w_rq_next;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_result    <= w_fix_result;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_040729_div_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ysyx_040729_div_seq
// Brief    : Self-checking bench for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_040729_div_seq;
    import ysyx_040729_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [2:0]  func3;
    logic        len_dw;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] last_res = '0;

    always #5 clk = ~clk;

    ysyx_040729_div_seq #(.DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .func3     (func3),
        .len_dw    (len_dw),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M semantics via native signed/unsigned arithmetic.
    function automatic logic [63:0] ref_div(input logic [2:0] f, input logic dw,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] ua, ub, q32, r32, s32;
        int          sa, sb;
        longint      la, lb;
        logic [63:0] q, r;
        if (dw) begin
            ua = a[31:0];
            ub = b[31:0];
            if (ub == 32'd0) begin
                q32 = '1;
                r32 = ua;
            end else if (f[0]) begin
                q32 = ua / ub;
                r32 = ua % ub;
            end else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
                q32 = ua;
                r32 = '0;
            end else begin
                sa  = signed'(ua);
                sb  = signed'(ub);
                q32 = unsigned'(sa / sb);
                r32 = unsigned'(sa % sb);
            end
            s32 = f[1] ? r32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (f[0]) begin
            q = a / b;
            r = a % b;
        end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else begin
            la = signed'(a);
            lb = signed'(b);
            q  = unsigned'(la / lb);
            r  = unsigned'(la % lb);
        end
        return f[1] ? r : q;
    endfunction

    function automatic bit ref_special(input logic [2:0] f, input logic dw,
                                       input logic [63:0] a, input logic [63:0] b);
        if (dw)
            return (b[31:0] == 32'd0) ||
                   (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 64'd0) || (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    function automatic logic [63:0] rand_opnd(input int kind);
        case (kind)
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_8000_0000;
            4:       return 64'($urandom_range(1, 20));
            5:       return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f, input logic dw,
                          input logic [63:0] a, input logic [63:0] b,
                          input int bp, input logic [63:0] exp);
        int          lat;
        int          exp_lat;
        logic [63:0] hold;
        exp_lat = ref_special(f, dw, a, b) ? 1 : (dw ? 34 : 66);
        @(negedge clk);
        check_val({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        src1      = a;
        src2      = b;
        func3     = f;
        len_dw    = dw;
        out_ready = (bp == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        src1     = {$urandom, $urandom};
        src2     = {$urandom, $urandom};
        func3    = {1'b1, 2'($urandom)};
        len_dw   = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, "_result"}, result, exp);
        if (bp > 0) begin
            hold     = result;
            in_valid = 1'b1;
            src2     = '0;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check_val({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
                check_val({tag, "_bp_result"}, result, hold);
                check_val({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check_val({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_post_busy"}, 64'(busy), 64'd0);
        last_res = exp;
    endtask

    initial begin
        logic [2:0]  f;
        logic        dw;
        logic [63:0] a, b;
        int          bp;
        bit          seen;

        rst = 1'b1; in_valid = 1'b0; src1 = '0; src2 = '0; func3 = FUNC3_DIV;
        len_dw = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_result", result, 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("div_m7_2",  FUNC3_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_m7_2",  FUNC3_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divu_z",    FUNC3_DIVU, 1'b0, 64'h1234, 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_z",    FUNC3_REMU, 1'b0, 64'h1234, 64'd0, 0, 64'h1234);
        run_op("div_ovf",   FUNC3_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 0, 64'h8000_0000_0000_0000);
        run_op("remw_ovf",  FUNC3_REM,  1'b1, 64'h8000_0000, '1, 0, 64'd0);
        run_op("divuw",     FUNC3_DIVU, 1'b1, 64'h0000_0001_0000_0064, 64'd7, 0, 64'd14);
        run_op("remuw",     FUNC3_REMU, 1'b1, 64'h0000_0001_0000_0064, 64'd7, 0, 64'd2);
        run_op("divw_m1",   FUNC3_DIV,  1'b1, 64'hFFFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remuw_z",   FUNC3_REMU, 1'b1, 64'h0000_0000_8000_0005, 64'h1_0000_0000, 0, 64'hFFFF_FFFF_8000_0005);
        run_op("bp_divu",   FUNC3_DIVU, 1'b0, 64'd1000, 64'd7, 10, 64'd142);

        // Flush in the middle of CALC, with a request presented alongside.
        @(negedge clk);
        in_valid = 1'b1; src1 = 64'd987654321; src2 = 64'd13; func3 = FUNC3_DIVU;
        len_dw = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check_val("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1; in_valid = 1'b1; src2 = 64'd0;
        @(negedge clk);
        check_val("flush_busy", 64'(busy), 64'd0);
        check_val("flush_out_valid", 64'(out_valid), 64'd0);
        check_val("flush_in_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_val("flush_not_accepted", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check_val("flush_no_valid", 64'(seen), 64'd0);
        check_val("flush_result_kept", result, last_res);

        // Reset pulsed mid-CALC.
        @(negedge clk);
        in_valid = 1'b1; src1 = 64'hFFFF_FFFF_FFFF_FF00; src2 = 64'd3; func3 = FUNC3_DIV;
        len_dw = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_result", result, 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        @(negedge clk);
        check_val("mid_rst_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < 40; k++) begin
            f  = {1'b1, 2'($urandom)};
            dw = 1'($urandom);
            a  = rand_opnd(int'($urandom_range(0, 9)));
            b  = rand_opnd(int'($urandom_range(0, 9)));
            bp = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op("rnd", f, dw, a, b, bp, ref_div(f, dw, a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_040729_div_seq.md
Name: ysyx_040729_div_seq

Overview:
- Multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W variants (DIVW/DIVUW/REMW/REMUW).
- Sits beside the execute-stage ALU and supplies its div/rem result path, replacing the single-cycle combinational divider.
- Uses a valid/ready handshake in both directions, so the pipeline stalls EX while the unit is busy.

Parameters:
- DATA_WIDTH, 64, operand and result width. Must be even; DATA_WIDTH/2 is the W-variant width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept a request; high iff state==IDLE
- src1  in  DATA_WIDTH  dividend
- src2  in  DATA_WIDTH  divisor
- func3  in  3  100 div, 101 divu, 110 rem, 111 remu. bit0=unsigned, bit1=remainder select
- len_dw  in  1  W variant; operate on the low DATA_WIDTH/2 bits only
- flush  in  1  synchronous kill of any in-flight or completed operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DATA_WIDTH  quotient or remainder, per func3[1]
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, result=0, busy=0, counter=0. in_ready=1 once rst deasserts.
- Accept: in_valid & in_ready & !flush at a clock edge ("cycle 0"). src1, src2, func3 and len_dw are latched; later input changes are ignored.
- Operand prep, N = len_dw ? DATA_WIDTH/2 : DATA_WIDTH:
  - W variants: use the low N bits, sign- or zero-extended per func3[0].
  - Signed ops take the absolute value of each operand and record the quotient sign (a_sign^b_sign) and remainder sign (a_sign).
- States:
  - IDLE -> CALC on accept. Special cases go directly to DONE instead.
  - CALC: one quotient bit per cycle; 7-bit counter loaded with N, decrements each cycle. Counter==1 -> FIX.
  - FIX: negate quotient/remainder per recorded signs. For W, sign-extend bit N-1 of the selected value into the upper bits. Load result -> DONE.
  - DONE: out_valid=1. out_valid & out_ready -> IDLE.
- Latency: out_valid first high N+2 cycles after the accept edge (66 for 64-bit, 34 for W).
- Special cases (evaluated at accept; out_valid high 1 cycle after accept; no CALC):
  - Divisor==0 (within N bits): quotient = all ones (W: sign-extended 32-bit all ones), remainder = dividend (W: sign-extended low 32).
  - Signed overflow, dividend = most-negative N-bit value and divisor = -1: quotient = dividend (sign-extended), remainder = 0.
- Backpressure: result and out_valid hold stable while out_ready=0. No new request is accepted until the result handshake completes; in_ready is never high in the same cycle as out_valid.
- flush: at the next edge, state=IDLE and out_valid=0; result keeps its last value. A request presented in the flush cycle is not accepted.
- Reset asserted mid-operation: immediate return to reset values; no partial result is exposed.
- Remainder sign follows the dividend. Quotient truncates toward zero.

Decomposition:
- Shared package ysyx_040729_pkg holds:
  - func3 encodings DIV/DIVU/REM/REMU
  - state enum {IDLE, CALC, FIX, DONE}
  - DIV_CNT_W = 7
- One natural sub-module, ysyx_040729_div_prep (combinational). It handles:
  - W narrowing and extension
  - absolute values
  - sign flags
  - special-case detection with the special result
- The CALC datapath (a 2N-bit shift/subtract register) stays in the top module.

Test Plan:
- DIV src1=0xFFFFFFFFFFFFFFF9 (-7), src2=2, out_ready=1 -> result 0xFFFFFFFFFFFFFFFD, out_valid first high 66 cycles after accept. Same operands with REM -> 0xFFFFFFFFFFFFFFFF.
- DIVU src1=0x1234, src2=0 -> result 0xFFFFFFFFFFFFFFFF one cycle after accept. REMU with the same operands -> 0x1234.
- DIV src1=0x8000000000000000, src2=0xFFFFFFFFFFFFFFFF -> 0x8000000000000000 after 1 cycle. REMW src1=0x80000000, src2=0xFFFFFFFFFFFFFFFF -> 0.
- DIVUW src1=0x0000000100000064, src2=7 -> 14 after 34 cycles. REMUW with the same operands -> 2. DIVW src1=0xFFFFFFFF, src2=1 -> 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises. result stays stable, in_ready stays 0, and a new in_valid is not accepted until the cycle after out_ready=1.
- Flush at CALC cycle 20 with in_valid=1 in the same cycle -> next cycle IDLE, busy=0, no out_valid ever for the killed op, and the coincident request is not accepted. Repeat with rst pulsed mid-CALC -> out_valid=0 and result=0 immediately.
